// File: rtl/muldiv32.sv
// muldiv32: iterative 32-bit multiply/divide unit that owns the HI/LO registers.
// One radix-2 step per cycle for 32 cycles, then a single sign-fix cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for Start; Mthi/Mtlo writes are honoured here
// CALC  | 32 shift-add (multiply) or restoring shift-subtract (divide) steps
// FIX   | two's-complement sign correction, HI/LO write, Done pulse
module muldiv32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] Read_data_1,
  input  logic [31:0] Read_data_2,
  input  logic        Mthi,
  input  logic        Mtlo,
  output logic        Busy,
  output logic        Done,
  output logic        Div_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [4:0]  cnt;

  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [31:0] opnd;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [63:0] acc;

  logic        neg_res;
  logic        neg_rem;
  logic        div_by_zero;
  logic [31:0] dividend_raw;

  // Operand decode at issue: signedness and magnitudes
  logic        op_signed;
  logic        op_div;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  // Iteration datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] div_next;

  // Sign-fix datapath
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Issue-time decode of the incoming request
  always_comb begin
    op_signed = ~Op[0];
    op_div    = Op[1];
    sign_a    = op_signed & Read_data_1[31];
    sign_b    = op_signed & Read_data_2[31];
    abs_a     = sign_a ? (~Read_data_1 + 32'd1) : Read_data_1;
    abs_b     = sign_b ? (~Read_data_2 + 32'd1) : Read_data_2;
  end

  // One radix-2 step for each operation kind
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
    mul_next = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

    // Remainder stays below the divisor, so the shifted value fits 33 bits.
    div_sh   = acc[63:31];
    div_diff = div_sh - {1'b0, opnd};
    div_next = div_diff[32] ? {div_sh[31:0], acc[30:0], 1'b0}
                            : {div_diff[31:0], acc[30:0], 1'b1};
  end

  // Final sign correction; remainder follows the dividend's sign
  always_comb begin
    prod_fix = neg_res ? (~acc + 64'd1) : acc;
    quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  // Control FSM, iteration registers and HI/LO ownership
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      op_q         <= 2'b00;
      cnt          <= 5'd0;
      opnd         <= 32'd0;
      acc          <= 64'd0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      div_by_zero  <= 1'b0;
      dividend_raw <= 32'd0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Div_zero     <= 1'b0;
      HI           <= 32'd0;
      LO           <= 32'd0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_q         <= Op;
            cnt          <= 5'd0;
            neg_res      <= sign_a ^ sign_b;
            neg_rem      <= op_div & sign_a;
            div_by_zero  <= op_div & (Read_data_2 == 32'd0);
            dividend_raw <= Read_data_1;
            if (op_div) begin
              opnd <= abs_b;
              acc  <= {32'd0, abs_a};
            end else begin
              opnd <= abs_a;
              acc  <= {32'd0, abs_b};
            end
            Busy     <= 1'b1;
            Div_zero <= 1'b0;
            state    <= CALC;
          end else begin
            // Both writes land when Mthi and Mtlo arrive together.
            if (Mthi) HI <= Read_data_1;
            if (Mtlo) LO <= Read_data_1;
          end
        end

        CALC: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end

        FIX: begin
          if (op_q[1]) begin
            // Divide-by-zero runs the full iteration, then reports fixed values.
            if (div_by_zero) begin
              HI       <= dividend_raw;
              LO       <= 32'hFFFF_FFFF;
              Div_zero <= 1'b1;
            end else begin
              HI <= rem_fix;
              LO <= quo_fix;
            end
          end else begin
            HI <= prod_fix[63:32];
            LO <= prod_fix[31:0];
          end
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
